// File: rtl/calc_datapath.sv
// Serial-entry calculator datapath: shift-in number register, opcode register,
// combinational ALU, and accumulator, with a muxed display output.
module calc_datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_number,
   input  logic        clear_number,
   input  logic        inputRegD,
   input  logic        inSelect,
   input  logic        load_result,
   input  logic        clear_result,
   input  logic        load_code,
   input  logic        clear_code,
   input  logic [2:0]  OpCode,
   input  logic        sel_display,
   output logic [15:0] finalOutput
);

   logic [15:0] numReg;
   logic [15:0] accReg;
   logic [2:0]  codeReg;
   logic [15:0] aluResult;
   logic [15:0] accNext;

   // All arithmetic wraps at 16 bits; no carry or overflow is kept.
   function automatic logic [15:0] aluOp(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
      logic [31:0] prod;
      prod = 32'(a) * 32'(b);
      case (op)
         3'b000:  aluOp = a + b;
         3'b001:  aluOp = a - b;
         3'b010:  aluOp = prod[15:0];
         3'b011:  aluOp = a & b;
         3'b100:  aluOp = a | b;
         3'b101:  aluOp = a ^ b;
         3'b110:  aluOp = {a[14:0], 1'b0};
         3'b111:  aluOp = b;
         default: aluOp = 16'h0000;
      endcase
   endfunction

   // ALU result and accumulator source selection.
   always_comb begin
      aluResult = aluOp(codeReg, accReg, numReg);
      if (inSelect) begin
         accNext = aluResult;
      end else begin
         accNext = numReg;
      end
   end

   // Number register: serial shift-in, clear has priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         numReg <= 16'h0000;
      end else if (clear_number) begin
         numReg <= 16'h0000;
      end else if (load_number) begin
         numReg <= {numReg[14:0], inputRegD};
      end
   end

   // Opcode register: clear has priority over load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         codeReg <= 3'b000;
      end else if (clear_code) begin
         codeReg <= 3'b000;
      end else if (load_code) begin
         codeReg <= OpCode;
      end
   end

   // Accumulator: clear has priority over load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accReg <= 16'h0000;
      end else if (clear_result) begin
         accReg <= 16'h0000;
      end else if (load_result) begin
         accReg <= accNext;
      end
   end

   // Display mux follows sel_display in the same cycle.
   always_comb begin
      if (sel_display) begin
         finalOutput = accReg;
      end else begin
         finalOutput = numReg;
      end
   end

endmodule

// File: tb/tb_calc_datapath.sv
// Randomized and directed bench for calc_datapath against an arithmetic reference model.
module tb_calc_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_number, clear_number, inputRegD, inSelect;
   logic        load_result, clear_result, load_code, clear_code;
   logic [2:0]  OpCode;
   logic        sel_display;
   logic [15:0] finalOutput;

   int checks = 0;
   int errors = 0;

   logic [15:0] mNum, mAcc;
   logic [2:0]  mCode;

   calc_datapath dut (
      .clk(clk), .reset(reset),
      .load_number(load_number), .clear_number(clear_number), .inputRegD(inputRegD),
      .inSelect(inSelect), .load_result(load_result), .clear_result(clear_result),
      .load_code(load_code), .clear_code(clear_code), .OpCode(OpCode),
      .sel_display(sel_display), .finalOutput(finalOutput)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] refAlu(input logic [2:0] op, input logic [15:0] accV,
                                          input logic [15:0] numV);
      longint a, b, r;
      a = longint'(accV);
      b = longint'(numV);
      case (op)
         3'd0:    r = (a + b) % 65536;
         3'd1:    r = (a - b + 65536) % 65536;
         3'd2:    r = (a * b) % 65536;
         3'd3:    r = longint'(accV & numV);
         3'd4:    r = longint'(accV | numV);
         3'd5:    r = longint'(accV ^ numV);
         3'd6:    r = (a * 2) % 65536;
         default: r = b;
      endcase
      return r[15:0];
   endfunction

   task automatic idle();
      load_number = 1'b0; clear_number = 1'b0; inputRegD = 1'b0; inSelect = 1'b0;
      load_result = 1'b0; clear_result = 1'b0; load_code = 1'b0; clear_code = 1'b0;
      OpCode = 3'b000;
   endtask

   task automatic showBoth(input string tag);
      logic keep;
      keep = sel_display;
      sel_display = 1'b0;
      #1 checkVal({tag, "_num"}, finalOutput, mNum);
      sel_display = 1'b1;
      #1 checkVal({tag, "_acc"}, finalOutput, mAcc);
      sel_display = keep;
   endtask

   // Caller sets controls after a negedge; one clock edge is applied and checked.
   task automatic tick(input string tag);
      logic [15:0] nNum, nAcc;
      logic [2:0]  nCode;
      nNum = mNum; nAcc = mAcc; nCode = mCode;
      if (clear_number) nNum = 16'h0000;
      else if (load_number) nNum = 16'((int'(mNum) * 2 + int'(inputRegD)) % 65536);
      if (clear_code) nCode = 3'b000;
      else if (load_code) nCode = OpCode;
      if (clear_result) nAcc = 16'h0000;
      else if (load_result) nAcc = inSelect ? refAlu(mCode, mAcc, mNum) : mNum;
      @(posedge clk);
      mNum = nNum; mAcc = nAcc; mCode = nCode;
      #1;
      showBoth(tag);
      @(negedge clk);
      idle();
   endtask

   task automatic shiftBit(input logic b);
      load_number = 1'b1; inputRegD = b;
      tick("shift");
   endtask

   task automatic setCode(input logic [2:0] op);
      load_code = 1'b1; OpCode = op;
      tick("code");
   endtask

   task automatic loadAcc(input logic viaAlu);
      load_result = 1'b1; inSelect = viaAlu;
      tick("loadacc");
   endtask

   task automatic clearNum();
      clear_number = 1'b1;
      tick("clrnum");
   endtask

   task automatic midReset();
      #2 reset = 1'b1;
      mNum = 16'h0000; mAcc = 16'h0000; mCode = 3'b000;
      sel_display = 1'b0;
      #1 checkVal("rst_sel0", finalOutput, 16'h0000);
      sel_display = 1'b1;
      #1 checkVal("rst_sel1", finalOutput, 16'h0000);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] held0, held1;
      idle();
      sel_display = 1'b0;
      reset = 1'b1;
      mNum = 16'h0000; mAcc = 16'h0000; mCode = 3'b000;
      #1 checkVal("por_num", finalOutput, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // serial entry
      sel_display = 1'b0;
      shiftBit(1'b1); shiftBit(1'b0); shiftBit(1'b1);
      #1 checkVal("serial101", finalOutput, 16'h0005);
      for (int i = 0; i < 17; i++) shiftBit(1'b1);
      #1 checkVal("serial17", finalOutput, 16'hFFFF);

      // add
      clearNum(); shiftBit(1'b1); shiftBit(1'b0); shiftBit(1'b1);
      loadAcc(1'b0);
      clearNum(); shiftBit(1'b1); shiftBit(1'b1);
      setCode(3'b000);
      loadAcc(1'b1);
      sel_display = 1'b1;
      #1 checkVal("add8", finalOutput, 16'h0008);

      // subtract wrap
      clearNum(); shiftBit(1'b1); shiftBit(1'b0); shiftBit(1'b0); shiftBit(1'b1);
      setCode(3'b001);
      loadAcc(1'b1);
      #1 checkVal("subwrap", finalOutput, 16'hFFFF);

      // multiply overflow
      clearNum(); shiftBit(1'b1);
      for (int i = 0; i < 8; i++) shiftBit(1'b0);
      loadAcc(1'b0);
      setCode(3'b010);
      loadAcc(1'b1);
      #1 checkVal("mulwrap", finalOutput, 16'h0000);

      // priority
      clearNum(); shiftBit(1'b1); loadAcc(1'b0);
      clear_result = 1'b1; load_result = 1'b1;
      tick("clr_vs_load");
      #1 checkVal("clrres_prio", finalOutput, 16'h0000);
      loadAcc(1'b0);
      clear_code = 1'b1; load_code = 1'b1; OpCode = 3'b101;
      tick("clrcode_prio");
      loadAcc(1'b1);
      #1 checkVal("code_is_add", finalOutput, 16'h0002);

      // hold
      shiftBit(1'b1);
      sel_display = 1'b0; #1 held0 = finalOutput;
      sel_display = 1'b1; #1 held1 = finalOutput;
      for (int i = 0; i < 5; i++) tick("hold");
      sel_display = 1'b0; #1 checkVal("hold_num", finalOutput, held0);
      sel_display = 1'b1; #1 checkVal("hold_acc", finalOutput, held1);

      // async reset with nonzero registers, then reset held over an edge with enables
      midReset();
      shiftBit(1'b1); shiftBit(1'b1); loadAcc(1'b0); setCode(3'b110);
      #2 reset = 1'b1;
      load_number = 1'b1; inputRegD = 1'b1; load_result = 1'b1; load_code = 1'b1; OpCode = 3'b011;
      mNum = 16'h0000; mAcc = 16'h0000; mCode = 3'b000;
      @(posedge clk); #1;
      showBoth("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      idle();
      shiftBit(1'b1);
      sel_display = 1'b0;
      #1 checkVal("post_rst_shift", finalOutput, 16'h0001);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            midReset();
         end else begin
            load_number  = 1'($urandom_range(0, 1));
            inputRegD    = 1'($urandom_range(0, 1));
            clear_number = ($urandom_range(0, 9) == 0);
            load_result  = 1'($urandom_range(0, 1));
            inSelect     = 1'($urandom_range(0, 1));
            clear_result = ($urandom_range(0, 9) == 0);
            load_code    = ($urandom_range(0, 3) == 0);
            clear_code   = ($urandom_range(0, 15) == 0);
            OpCode       = 3'($urandom_range(0, 7));
            sel_display  = 1'($urandom_range(0, 1));
            tick("rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_datapath.md
CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 The block SHALL have: clk  input  1  rising-edge clock for all registers.
REQ-002 The block SHALL have: reset  input  1  asynchronous, active-high; clears all registers.
REQ-003 The block SHALL have: load_number  input  1  shift-enable for the number register.
REQ-004 The block SHALL have: clear_number  input  1  synchronous clear of the number register.
REQ-005 The block SHALL have: inputRegD  input  1  serial data bit shifted into the number register.
REQ-006 The block SHALL have: inSelect  input  1  accumulator source select: 0 = number register, 1 = ALU result.
REQ-007 The block SHALL have: load_result  input  1  accumulator load enable.
REQ-008 The block SHALL have: clear_result  input  1  synchronous clear of the accumulator.
REQ-009 The block SHALL have: load_code  input  1  opcode register load enable.
REQ-010 The block SHALL have: clear_code  input  1  synchronous clear of the opcode register.
REQ-011 The block SHALL have: OpCode  input  3  opcode value captured by load_code.
REQ-012 The block SHALL have: sel_display  input  1  display select: 0 = number register, 1 = accumulator.
REQ-013 The block SHALL have: finalOutput  output  16  displayed value.
REQ-014 One clock; reset is asynchronous and active-high.

Function
REQ-015 The number register SHALL be 16-bit; with load_number=1 at a clock edge: NUM <= {NUM[14:0], inputRegD} (MSB discarded).
REQ-016 clear_number=1 SHALL set NUM to 0x0000 at the clock edge, taking priority over load_number.
REQ-017 The opcode register SHALL be 3-bit; load_code=1 captures OpCode; clear_code=1 sets it to 3'b000 with priority over load_code.
REQ-018 The ALU SHALL be purely combinational with A = ACC, B = NUM, op = opcode register (not the OpCode port).
REQ-019 ALU ops SHALL be: 000 A+B; 001 A-B; 010 low 16 bits of A*B; 011 A AND B; 100 A OR B; 101 A XOR B; 110 A<<1 (LSB 0); 111 B.
REQ-020 All ALU arithmetic SHALL be unsigned modulo 2^16; carries, borrows and upper product bits are discarded without flags.
REQ-021 The accumulator (ACC, 16-bit) SHALL load NUM when inSelect=0, or the ALU result when inSelect=1, on a clock edge with load_result=1.
REQ-022 clear_result=1 SHALL set ACC to 0x0000 at the clock edge, taking priority over load_result.
REQ-023 Registers SHALL update simultaneously on the same edge; an ACC load uses the pre-edge NUM and opcode values even if they change on that edge.
REQ-024 With no enable or clear asserted, every register SHALL hold its value.
REQ-025 finalOutput SHALL be combinational: NUM when sel_display=0, ACC when sel_display=1; it changes in the same cycle as sel_display.
REQ-026 Latency SHALL be one clock from any enable or clear to the register update visible on finalOutput.

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, set NUM=0x0000, ACC=0x0000 and opcode=3'b000, giving finalOutput=0x0000 for either sel_display value.
REQ-028 reset SHALL override all enables and clears while asserted, including in the middle of a serial shift; the first edge after deassertion SHALL operate normally.

Verification
REQ-029 Reset check: reset=1 mid-cycle with nonzero registers -> finalOutput=0x0000 immediately for sel_display=0 and 1.
REQ-030 Serial entry: shift bits 1,0,1 with load_number=1, sel_display=0 -> finalOutput=0x0005; 17 shifts of 1 -> 0xFFFF (MSB dropped).
REQ-031 Add: NUM=5, inSelect=0 and load_result -> ACC=5; clear_number, shift in 3, opcode 000, inSelect=1 and load_result -> sel_display=1 shows 0x0008.
REQ-032 Subtract wrap: ACC=0x0008, NUM=0x0009, opcode 001, load via ALU -> ACC=0xFFFF; opcode 010 with ACC=0x0100, NUM=0x0100 -> 0x0000.
REQ-033 Priority: clear_result and load_result together -> ACC=0x0000; clear_code and load_code with OpCode=3'b101 -> opcode 000 (next ALU load performs an add).
REQ-034 Hold: all enables low for 5 cycles -> finalOutput unchanged for both sel_display values.
